// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit codes (bit6=a .. bit0=g), digit width, converter FSM states.
// Also used by the BCD display driver, so code constants must stay in sync with it.
package seg7_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [6:0] SEG_ZERO  = 7'b1111110;
   localparam logic [6:0] SEG_ONE   = 7'b0110000;
   localparam logic [6:0] SEG_TWO   = 7'b1101101;
   localparam logic [6:0] SEG_THREE = 7'b1111001;
   localparam logic [6:0] SEG_FOUR  = 7'b0110011;
   localparam logic [6:0] SEG_FIVE  = 7'b1011011;
   localparam logic [6:0] SEG_SIX   = 7'b1011111;
   localparam logic [6:0] SEG_SEVEN = 7'b1110000;
   localparam logic [6:0] SEG_EIGHT = 7'b1111111;
   localparam logic [6:0] SEG_NINE  = 7'b1111011;

   typedef enum logic [1:0] {IDLE, DECODE, SHIFT, DONE} state_t;

   // Reverse double-dabble correction: a shifted nibble >= 8 carried a 10 in from above.
   function automatic logic [DIGIT_W-1:0] nib_adj(input logic [DIGIT_W-1:0] n);
      return (n >= 4'd8) ? n - 4'd3 : n;
   endfunction

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational 7-segment code to decimal digit with a legality flag.
// SEG7_BLANK_ZERO_EN: when defined, an all-off code is accepted as a blanked zero.
module seg7_to_digit
   import seg7_pkg::*;
(
   input  logic [6:0]         code,
   output logic [DIGIT_W-1:0] digit,
   output logic               valid
);

   always_comb begin
      digit = '0;
      valid = 1'b1;
      case (code)
         SEG_ZERO:  digit = 4'd0;
         SEG_ONE:   digit = 4'd1;
         SEG_TWO:   digit = 4'd2;
         SEG_THREE: digit = 4'd3;
         SEG_FOUR:  digit = 4'd4;
         SEG_FIVE:  digit = 4'd5;
         SEG_SIX:   digit = 4'd6;
         SEG_SEVEN: digit = 4'd7;
         SEG_EIGHT: digit = 4'd8;
         SEG_NINE:  digit = 4'd9;
`ifdef SEG7_BLANK_ZERO_EN
         7'b0000000: digit = 4'd0;
`endif
         default:   valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_bin_decode.sv
// Three 7-segment digits back to W-bit binary via reverse double dabble, one bit per clock.
// start/busy/done handshake; optional blanked-zero digits under SEG7_BLANK_ZERO_EN.
module seg7_bin_decode
   import seg7_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [6:0]   d0,
   input  logic [6:0]   d1,
   input  logic [6:0]   d2,
   output logic [W-1:0] bin,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic         err
);

   localparam logic [4:0] CNT_LAST = 5'(W - 1);

   state_t state, state_nx;

   logic [6:0]         c0_q, c1_q, c2_q;
   logic [DIGIT_W-1:0] dig0, dig1, dig2;
   logic               v0, v1, v2;
   logic               legal;
   logic [11:0]        bcd;
   logic [11:0]        bcd_sh;
   logic [11:0]        bcd_adj;
   logic [4:0]         cnt;

   seg7_to_digit u_dig0 (.code(c0_q), .digit(dig0), .valid(v0));
   seg7_to_digit u_dig1 (.code(c1_q), .digit(dig1), .valid(v1));
   seg7_to_digit u_dig2 (.code(c2_q), .digit(dig2), .valid(v2));

   assign legal   = v0 & v1 & v2;
   assign bcd_sh  = {1'b0, bcd[11:1]};
   assign bcd_adj = {nib_adj(bcd_sh[11:8]), nib_adj(bcd_sh[7:4]), nib_adj(bcd_sh[3:0])};

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = DECODE;
         DECODE:  state_nx = legal ? SHIFT : DONE;
         SHIFT:   if (cnt == CNT_LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_q <= '0;
         c1_q <= '0;
         c2_q <= '0;
         bcd  <= '0;
         bin  <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
         err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  c0_q <= d0;
                  c1_q <= d1;
                  c2_q <= d2;
               end
            end
            DECODE: begin
               bin <= '0;
               cnt <= '0;
               ovf <= 1'b0;
               err <= ~legal;
               bcd <= legal ? {dig2, dig1, dig0} : 12'd0;
            end
            SHIFT: begin
               bin <= {bcd[0], bin[W-1:1]};
               bcd <= bcd_adj;
               cnt <= cnt + 5'd1;
               // Residual decided on the final shift so ovf is valid alongside done.
               if (cnt == CNT_LAST) ovf <= |bcd_adj;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_bin_decode.sv
// Randomized and directed scoreboard bench for seg7_bin_decode (W=8).
module tb_seg7_bin_decode;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [6:0]   d0, d1, d2;
   logic [W-1:0] bin;
   logic         busy, done, ovf, err;

   seg7_bin_decode #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .d0(d0), .d1(d1), .d2(d2),
      .bin(bin), .busy(busy), .done(done), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] bin;
      logic         ovf;
      logic         err;
      int           at;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit dec(input logic [6:0] c, output int v);
      v = 0;
      for (int i = 0; i < 10; i++)
         if (seg_tab[i] == c) begin
            v = i;
            return 1'b1;
         end
`ifdef SEG7_BLANK_ZERO_EN
      if (c == 7'b0000000) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Call just after a rising edge; start is sampled at the next edge.
   task automatic issue(input logic [6:0] c2, input logic [6:0] c1, input logic [6:0] c0, input bit push);
      exp_t e;
      int h, t, u, val;
      bit ok;
      ok = dec(c2, h) & dec(c1, t) & dec(c0, u);
      val = h * 100 + t * 10 + u;
      e.err = !ok;
      e.bin = ok ? W'(val % (1 << W)) : '0;
      e.ovf = ok && (val >= (1 << W));
      e.at  = cyc + (ok ? W + 2 : 2);
      d2 = c2; d1 = c1; d0 = c0;
      start = 1'b1;
      if (push) q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      total++;
      if (!done) begin
         bad++;
         $display("FAIL done_timeout: got done=0 want done=1 within 40 cycles (cycle %0d)", cyc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic convert(input logic [6:0] c2, input logic [6:0] c1, input logic [6:0] c0);
      issue(c2, c1, c0, 1'b1);
      wait_done();
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 want done=0 (cycle %0d)", cyc);
         end else begin
            m_e = q.pop_front();
            check("bin", 32'(bin), 32'(m_e.bin));
            check("ovf", 32'(ovf), 32'(m_e.ovf));
            check("err", 32'(err), 32'(m_e.err));
            check("done_cycle", cyc, m_e.at);
         end
      end
   end

   initial begin
      int k, dc;
      rst_n = 1'b0; start = 1'b0; d0 = '0; d1 = '0; d2 = '0;
      #2;
      check("rst_bin", 32'(bin), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_err", 32'(err), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 255 with busy window: high for W+2 cycles after start is sampled.
      k = cyc;
      issue(seg_tab[2], seg_tab[5], seg_tab[5], 1'b1);
      while (cyc < k + W + 4) begin
         @(negedge clk);
         check("busy_window", 32'(busy), 32'((cyc >= k + 1) && (cyc <= k + W + 2)));
      end
      @(posedge clk);
      #1;
      check("bin_255_hold", 32'(bin), 32'hFF);

      convert(seg_tab[0], seg_tab[0], seg_tab[0]);
      convert(seg_tab[1], seg_tab[2], seg_tab[8]);
      check("bin_128_hold", 32'(bin), 32'h80);
      convert(seg_tab[2], seg_tab[5], seg_tab[6]);
      check("ovf_256_hold", 32'(ovf), 1);
      convert(seg_tab[9], seg_tab[9], seg_tab[9]);
      check("bin_999_hold", 32'(bin), 32'hE7);
      convert(seg_tab[3], 7'b0000001, seg_tab[4]);
      check("err_hold", 32'(err), 1);
      convert(7'b0000000, seg_tab[4], seg_tab[2]);

      // Second start mid-conversion must be ignored.
      dc = done_cnt;
      issue(seg_tab[1], seg_tab[0], seg_tab[0], 1'b1);
      repeat (2) @(posedge clk);
      #1 start = 1'b1; d2 = seg_tab[7]; d1 = seg_tab[7]; d0 = seg_tab[7];
      @(posedge clk);
      #1 start = 1'b0;
      repeat (W + 8) @(posedge clk);
      #1;
      check("single_done", done_cnt - dc, 1);

      // Reset mid-conversion aborts with no done.
      dc = done_cnt;
      issue(seg_tab[5], seg_tab[5], seg_tab[5], 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_bin", 32'(bin), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (W + 5) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - dc, 0);
      convert(seg_tab[0], seg_tab[4], seg_tab[2]);

      // start held high: back-to-back conversions, start in DONE cycle ignored.
      k = cyc;
      issue(seg_tab[1], seg_tab[7], seg_tab[3], 1'b1);
      #0 start = 1'b1;
      m_e.bin = 8'd173; m_e.ovf = 1'b0; m_e.err = 1'b0; m_e.at = k + 2 * W + 5;
      q.push_back(m_e);
      repeat (2 * W + 5) @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      for (int n = 0; n < 40; n++) begin
         logic [6:0] c [3];
         for (int j = 0; j < 3; j++)
            c[j] = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : seg_tab[$urandom_range(0, 9)];
         convert(c[2], c[1], c[0]);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (W + 4) @(posedge clk);
      #1;
      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
